// File: rtl/piece_move_scheduler.sv
// piece_move_scheduler: serialises gravity ticks and keyboard moves into a
// single one-outstanding command stream for the board-update engine. It owns
// the gravity and auto-repeat timebases and arbitrates with gravity first.
module piece_move_scheduler #(
   parameter int GRAVITY_DIV = 33554432,
   parameter int REPEAT_DIV  = 1048576
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] keyboard_signal,
   input  logic       pause,
   output logic       cmd_valid,
   output logic [1:0] cmd_op,
   input  logic       cmd_ready,
   input  logic       cmd_done,
   input  logic       cmd_landed,
   output logic       busy
);

   localparam int GW = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;
   localparam int RW = (REPEAT_DIV > 2) ? $clog2(REPEAT_DIV) : 1;
   localparam logic [GW-1:0] GCNT_LAST = GW'(GRAVITY_DIV - 1);
   localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_DIV - 1);

   localparam logic [1:0] OP_DOWN = 2'b00;
   localparam logic [1:0] KEY_IDLE = 2'b00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t        state;
   logic [GW-1:0] gcnt;
   logic [RW-1:0] rcnt;
   logic          grav_pend;
   logic          key_pend;
   logic [1:0]    key_op;
   logic [1:0]    key_q;

   logic landing;
   logic grav_tick;
   logic key_press;
   logic key_hold;
   logic key_repeat;
   logic take_grav;
   logic take_key;

   // Event decode: landing, timebase terminal counts, key edges and arbitration
   always_comb begin
      landing    = (state == WAIT) && cmd_done && cmd_landed && (cmd_op == OP_DOWN);
      grav_tick  = !pause && !landing && (gcnt == GCNT_LAST);
      key_press  = !pause && (keyboard_signal != KEY_IDLE) && (keyboard_signal != key_q);
      key_hold   = !pause && (keyboard_signal != KEY_IDLE) && (keyboard_signal == key_q);
      key_repeat = key_hold && (rcnt == RCNT_LAST);
      take_grav  = (state == IDLE) && grav_pend;
      take_key   = (state == IDLE) && !grav_pend && key_pend;
   end

   // Gravity timebase: landing restarts the interval and suppresses a coincident tick
   always_ff @(posedge clk) begin
      if (rst || landing) begin
         gcnt <= '0;
      end else if (!pause) begin
         if (gcnt == GCNT_LAST) gcnt <= '0;
         else                   gcnt <= gcnt + GW'(1);
      end
   end

   // Sticky gravity request; a new tick wins over the IDLE consume on the same edge
   always_ff @(posedge clk) begin
      if (rst)            grav_pend <= 1'b0;
      else if (grav_tick) grav_pend <= 1'b1;
      else if (take_grav) grav_pend <= 1'b0;
   end

   // Key sampler keeps tracking the input even while paused
   always_ff @(posedge clk) begin
      if (rst) key_q <= KEY_IDLE;
      else     key_q <= keyboard_signal;
   end

   // Auto-repeat timebase: counts only while the same key stays held and unpaused
   always_ff @(posedge clk) begin
      if (rst || landing) begin
         rcnt <= '0;
      end else if (!pause) begin
         if (key_hold && !key_repeat) rcnt <= rcnt + RW'(1);
         else                         rcnt <= '0;
      end
   end

   // Single-entry key request: latest press overwrites the op, set beats clear
   always_ff @(posedge clk) begin
      if (rst) begin
         key_pend <= 1'b0;
         key_op   <= KEY_IDLE;
      end else begin
         if (key_press) key_op <= keyboard_signal;
         if (key_press || key_repeat)  key_pend <= 1'b1;
         else if (take_key || landing) key_pend <= 1'b0;
      end
   end

   // Command FSM with registered valid/op; one command outstanding at a time
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_valid <= 1'b0;
         cmd_op    <= OP_DOWN;
      end else begin
         case (state)
            IDLE: begin
               if (take_grav) begin
                  cmd_op    <= OP_DOWN;
                  cmd_valid <= 1'b1;
                  state     <= ISSUE;
               end else if (take_key) begin
                  cmd_op    <= key_op;
                  cmd_valid <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cmd_done) state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               cmd_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_piece_move_scheduler.sv
// Testbench for piece_move_scheduler: directed scenarios plus randomized
// traffic, checked against an event-level reference model and a command
// scoreboard popped by an independent monitor.
module tb_piece_move_scheduler;

   localparam int GDIV = 16;
   localparam int RDIV = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] kb = 2'b00;
   logic       pause = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_done = 1'b0;
   logic       cmd_landed = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic       busy;

   piece_move_scheduler #(.GRAVITY_DIV(GDIV), .REPEAT_DIV(RDIV)) dut (
      .clk             (clk),
      .rst             (rst),
      .keyboard_signal (kb),
      .pause           (pause),
      .cmd_valid       (cmd_valid),
      .cmd_op          (cmd_op),
      .cmd_ready       (cmd_ready),
      .cmd_done        (cmd_done),
      .cmd_landed      (cmd_landed),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Reference model state: elapsed-cycle counts, pending requests, engine phase
   typedef struct {
      int op;
      int edge_no;
   } exp_t;

   int   edge_n = 0;
   int   g_el = 0;
   int   r_el = 0;
   bit   gp = 0;
   bit   kp = 0;
   int   keyop = 0;
   int   keyq = 0;
   int   phase = 0;   // 0 no command, 1 offered, 2 accepted awaiting done
   int   m_op = 0;
   exp_t sb[$];
   int   rise_e[$];
   int   rise_op[$];

   // Reference model, advanced on every rising edge from the sampled inputs
   always @(posedge clk) begin : model
      bit   tick, kset, land, take_g, take_k;
      int   old_keyop;
      exp_t e;
      if (rst) begin
         edge_n = 0; g_el = 0; r_el = 0; gp = 0; kp = 0;
         keyop = 0; keyq = 0; phase = 0; m_op = 0;
         sb.delete();
      end else begin
         edge_n++;
         tick = 0;
         kset = 0;
         land = (phase == 2) && cmd_done && cmd_landed && (m_op == 0);
         if (land) g_el = 0;
         else if (!pause) begin
            g_el++;
            if (g_el == GDIV) begin
               g_el = 0;
               tick = 1;
            end
         end
         old_keyop = keyop;
         if (!pause) begin
            if (kb != 0 && int'(kb) != keyq) begin
               kset = 1;
               keyop = int'(kb);
               r_el = 0;
            end else if (kb != 0) begin
               r_el++;
               if (r_el == RDIV) begin
                  r_el = 0;
                  kset = 1;
               end
            end else begin
               r_el = 0;
            end
         end
         if (land) r_el = 0;
         keyq = int'(kb);
         take_g = 0;
         take_k = 0;
         case (phase)
            0: begin
               if (gp) begin
                  take_g = 1; m_op = 0; phase = 1;
               end else if (kp) begin
                  take_k = 1; m_op = old_keyop; phase = 1;
               end
            end
            1: if (cmd_ready) phase = 2;
            default: if (cmd_done) phase = 0;
         endcase
         if (take_g || take_k) begin
            e.op = m_op;
            e.edge_no = edge_n;
            sb.push_back(e);
         end
         gp = tick || (gp && !take_g);
         kp = kset || (kp && !take_k && !land);
      end
   end

   // Monitor: compares outputs mid-cycle and pops the scoreboard on each new command
   logic prev_valid = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         check("cmd_valid", int'(cmd_valid), int'(phase == 1));
         check("busy", int'(busy), int'(phase != 0));
         if (phase == 1) check("cmd_op", int'(cmd_op), m_op);
         if (cmd_valid && !prev_valid) begin
            rise_e.push_back(edge_n);
            rise_op.push_back(int'(cmd_op));
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got op %0d after edge %0d, expected no command", cmd_op, edge_n);
            end else begin
               e = sb.pop_front();
               check("sb_op", int'(cmd_op), e.op);
               check("sb_edge", edge_n, e.edge_no);
            end
         end
      end
      prev_valid = cmd_valid;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_to(input int e);
      int guard;
      guard = 0;
      while (edge_n < e && guard < 1000) begin
         tick();
         guard++;
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      check("rst_cmd_valid", int'(cmd_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cmd_op", int'(cmd_op), 0);
      rise_e.delete();
      rise_op.delete();
      rst = 1'b0;
   endtask

   function automatic int rise_at(input int i);
      if (i < rise_e.size()) return rise_e[i];
      return -1;
   endfunction

   function automatic int op_at(input int i);
      if (i < rise_op.size()) return rise_op[i];
      return -1;
   endfunction

   initial begin
      // Gravity only: downs after edges 17 and 33
      cmd_ready = 1; cmd_done = 1; cmd_landed = 0; kb = 0; pause = 0;
      do_reset(2);
      run_to(40);
      check("grav_count", rise_e.size(), 2);
      check("grav_t0", rise_at(0), 17);
      check("grav_t1", rise_at(1), 33);
      check("grav_op0", op_at(0), 0);

      // Held rotate with auto-repeat, then a single left tap
      do_reset(2);
      run_to(1);  kb = 2'b11;
      run_to(21); kb = 2'b00;
      run_to(29); kb = 2'b01;
      run_to(30); kb = 2'b00;
      run_to(45);
      check("rot_t0", rise_at(0), 3);
      check("rot_op0", op_at(0), 3);
      check("rot_t1", rise_at(1), 11);
      check("rot_t2", rise_at(2), 17);
      check("rot_op2", op_at(2), 0);
      check("rot_t3", rise_at(3), 20);
      check("left_t", rise_at(4), 31);
      check("left_op", op_at(4), 1);

      // Gravity priority over a coincident key, engine stalls for 10 cycles
      do_reset(2);
      run_to(15); kb = 2'b10;
      run_to(16); kb = 2'b00; cmd_ready = 0;
      run_to(27); cmd_ready = 1;
      run_to(40);
      check("prio_t0", rise_at(0), 17);
      check("prio_op0", op_at(0), 0);
      check("prio_t1", rise_at(1), 30);
      check("prio_op1", op_at(1), 2);

      // Landing discards a pending key and restarts gravity (d = 19)
      cmd_landed = 1;
      do_reset(2);
      run_to(17); kb = 2'b01;
      run_to(18); kb = 2'b00;
      run_to(45);
      check("land_count", rise_e.size(), 2);
      check("land_t1", rise_at(1), 36);
      check("land_op1", op_at(1), 0);
      cmd_landed = 0;

      // Pause for edges 5..54 with key activity inside the pause
      do_reset(2);
      run_to(4);  pause = 1;
      run_to(9);  kb = 2'b01;
      run_to(11); kb = 2'b00;
      run_to(54); pause = 0;
      run_to(70);
      check("pause_count", rise_e.size(), 1);
      check("pause_t0", rise_at(0), 67);

      // Reset while a command waits for done; held left key reissues after edge 2
      do_reset(2);
      cmd_ready = 1; cmd_done = 0;
      run_to(20);
      check("abort_busy_before", int'(busy), 1);
      kb = 2'b01;
      do_reset(1);
      run_to(4);
      check("abort_t0", rise_at(0), 2);
      check("abort_op0", op_at(0), 1);

      // Randomized traffic against the model
      kb = 0; cmd_done = 1;
      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) kb = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         cmd_ready  = ($urandom_range(0, 2) != 0);
         cmd_done   = ($urandom_range(0, 1) != 0);
         cmd_landed = ($urandom_range(0, 2) == 0);
         rst        = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 0;
      pause = 0;
      tick();
      @(negedge clk);
      #1;
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
